// File: rtl/clarke_arb_if.sv
// Bundle of request, result and shared-Clarke-unit signals for clarke_arb.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface clarke_arb_if #(
   parameter int D_WIDTH = 18
);
   logic [1:0]                in_valid;
   logic [1:0]                in_ready;
   logic signed [D_WIDTH-1:0] a0;
   logic signed [D_WIDTH-1:0] b0;
   logic signed [D_WIDTH-1:0] a1;
   logic signed [D_WIDTH-1:0] b1;
   logic [1:0]                out_valid;
   logic [1:0]                out_ready;
   logic signed [D_WIDTH-1:0] alpha0;
   logic signed [D_WIDTH-1:0] beta0;
   logic signed [D_WIDTH-1:0] alpha1;
   logic signed [D_WIDTH-1:0] beta1;
   logic                      cl_start;
   logic signed [D_WIDTH-1:0] cl_a;
   logic signed [D_WIDTH-1:0] cl_b;
   logic signed [D_WIDTH-1:0] cl_alpha;
   logic signed [D_WIDTH-1:0] cl_beta;
   logic                      cl_done;
   logic                      busy;
   logic                      err;

   modport slave (
      input  in_valid, a0, b0, a1, b1, out_ready, cl_alpha, cl_beta, cl_done,
      output in_ready, out_valid, alpha0, beta0, alpha1, beta1,
             cl_start, cl_a, cl_b, busy, err
   );

   modport master (
      output in_valid, a0, b0, a1, b1, out_ready, cl_alpha, cl_beta, cl_done,
      input  in_ready, out_valid, alpha0, beta0, alpha1, beta1,
             cl_start, cl_a, cl_b, busy, err
   );
endinterface

// File: rtl/clarke_arb.sv
// Two-channel round-robin arbiter in front of one shared Clarke-transform unit.
// Results are passed through bit-exact and held per channel until consumed.
module clarke_arb #(
   parameter int D_WIDTH = 18,
   parameter int LAT     = 1
) (
   input logic        clk,
   input logic        rstb,
   clarke_arb_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE
   } state_t;

   localparam logic [2:0] WAIT_INIT = 3'((LAT > 1) ? (LAT - 2) : 0);

   state_t                    state_q, state_d;
   logic [2:0]                waitCnt_q, waitCnt_d;
   logic                      rrPtr_q;
   logic                      grantCh_q;
   logic signed [D_WIDTH-1:0] opA_q;
   logic signed [D_WIDTH-1:0] opB_q;
   logic signed [D_WIDTH-1:0] alpha0_q, beta0_q, alpha1_q, beta1_q;
   logic [1:0]                outValid_q, outValid_d;
   logic                      err_q;

   logic [1:0]                eligible;
   logic                      grantValid;
   logic                      grantCh;
   logic [1:0]                inReady;

   // A channel still holding an unconsumed result is never eligible.
   always_comb begin
      eligible   = bus.in_valid & ~outValid_q;
      grantValid = 1'b0;
      grantCh    = 1'b0;
      if (state_q == ST_IDLE && rstb) begin
         if (eligible == 2'b11) begin
            grantValid = 1'b1;
            grantCh    = rrPtr_q;
         end else if (eligible[0]) begin
            grantValid = 1'b1;
            grantCh    = 1'b0;
         end else if (eligible[1]) begin
            grantValid = 1'b1;
            grantCh    = 1'b1;
         end
      end
      inReady = 2'b00;
      if (grantValid) begin
         inReady = grantCh ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      case (state_q)
         ST_IDLE: begin
            if (grantValid) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (LAT > 1) begin
               state_d   = ST_WAIT;
               waitCnt_d = WAIT_INIT;
            end else begin
               state_d = ST_CAPTURE;
            end
         end
         ST_WAIT: begin
            if (waitCnt_q == 3'd0) begin
               state_d = ST_CAPTURE;
            end else begin
               waitCnt_d = waitCnt_q - 3'd1;
            end
         end
         ST_CAPTURE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A consumed result drops its flag; a capture sets the granted channel's flag.
   always_comb begin
      outValid_d = outValid_q & ~bus.out_ready;
      if (state_q == ST_CAPTURE) begin
         outValid_d[grantCh_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= ST_IDLE;
         waitCnt_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rrPtr_q   <= 1'b0;
         grantCh_q <= 1'b0;
         opA_q     <= '0;
         opB_q     <= '0;
      end else if (grantValid) begin
         rrPtr_q   <= ~grantCh;
         grantCh_q <= grantCh;
         opA_q     <= grantCh ? bus.a1 : bus.a0;
         opB_q     <= grantCh ? bus.b1 : bus.b0;
      end
   end

   // Result registers only change on a capture, so they hold after consumption.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         alpha0_q   <= '0;
         beta0_q    <= '0;
         alpha1_q   <= '0;
         beta1_q    <= '0;
         outValid_q <= 2'b00;
         err_q      <= 1'b0;
      end else begin
         outValid_q <= outValid_d;
         if (state_q == ST_CAPTURE) begin
            if (grantCh_q) begin
               alpha1_q <= bus.cl_alpha;
               beta1_q  <= bus.cl_beta;
            end else begin
               alpha0_q <= bus.cl_alpha;
               beta0_q  <= bus.cl_beta;
            end
            if (!bus.cl_done) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.alpha0    = alpha0_q;
   assign bus.beta0     = beta0_q;
   assign bus.alpha1    = alpha1_q;
   assign bus.beta1     = beta1_q;
   assign bus.cl_start  = (state_q == ST_ISSUE);
   assign bus.cl_a      = opA_q;
   assign bus.cl_b      = opB_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.err       = err_q;

endmodule

// File: tb/tb_clarke_arb.sv
// Directed bench for clarke_arb: a LAT=1 and a LAT=3 instance, each fed by a
// behavioural Clarke unit whose results appear the cycle after cl_start.
module tb_clarke_arb;

   logic clk;
   logic rstb;
   logic forceDoneLow;
   int   vectorCount;
   int   missCount;

   clarke_arb_if #(.D_WIDTH(18)) bus ();
   clarke_arb_if #(.D_WIDTH(18)) bus3 ();

   clarke_arb #(.D_WIDTH(18), .LAT(1)) dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus.slave)
   );

   clarke_arb #(.D_WIDTH(18), .LAT(3)) dut3 (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic signed [17:0] betaOf(input logic signed [17:0] a,
                                                 input logic signed [17:0] b);
      longint t;
      t = (longint'(a) + 2 * longint'(b)) * 18918;
      return 18'(t >>> 15);
   endfunction

   // Behavioural shared unit: alpha = a, beta = (a + 2b) * 18918 >>> 15.
   logic signed [17:0] uAlpha, uBeta, uAlpha3, uBeta3;
   always @(posedge clk) begin
      if (bus.cl_start) begin
         uAlpha <= bus.cl_a;
         uBeta  <= betaOf(bus.cl_a, bus.cl_b);
      end
      if (bus3.cl_start) begin
         uAlpha3 <= bus3.cl_a;
         uBeta3  <= betaOf(bus3.cl_a, bus3.cl_b);
      end
   end
   assign bus.cl_alpha  = uAlpha;
   assign bus.cl_beta   = uBeta;
   assign bus.cl_done   = ~forceDoneLow;
   assign bus3.cl_alpha = uAlpha3;
   assign bus3.cl_beta  = uBeta3;
   assign bus3.cl_done  = 1'b1;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] ready);
      bus.in_valid  = valid;
      bus.out_ready = ready;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectorCount  = 0;
      missCount    = 0;
      forceDoneLow = 1'b0;
      rstb         = 1'b0;
      bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
      bus3.a0 = '0; bus3.b0 = '0; bus3.a1 = '0; bus3.b1 = '0;
      bus3.in_valid = 2'b00; bus3.out_ready = 2'b00;
      applyStimulus(2'b11, 2'b00);
      #3;
      checkOutput("rst_in_ready", bus.in_ready, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_cl_start", bus.cl_start, 0);
      checkOutput("rst_err", bus.err, 0);
      checkOutput("rst_alpha0", bus.alpha0, 0);
      checkOutput("rst_cl_a", bus.cl_a, 0);
      applyStimulus(2'b00, 2'b00);
      tick();
      rstb = 1'b1;
      tick();

      // Single channel 0 transaction, LAT=1
      bus.a0 = 18'sd16384; bus.b0 = 18'sd0;
      applyStimulus(2'b01, 2'b00);
      #1 checkOutput("t1_grant", bus.in_ready, 1);
      tick();
      applyStimulus(2'b00, 2'b00);
      #1 checkOutput("t1_cl_start", bus.cl_start, 1);
      checkOutput("t1_cl_a", bus.cl_a, 16384);
      checkOutput("t1_in_ready_busy", bus.in_ready, 0);
      tick();
      checkOutput("t1_capture_start", bus.cl_start, 0);
      checkOutput("t1_capture_ov", bus.out_valid, 0);
      tick();
      checkOutput("t1_ov", bus.out_valid, 1);
      checkOutput("t1_alpha0", bus.alpha0, 16384);
      checkOutput("t1_beta0", bus.beta0, 9459);
      checkOutput("t1_busy", bus.busy, 0);
      applyStimulus(2'b00, 2'b01);
      tick();
      checkOutput("t1_consumed", bus.out_valid, 0);
      checkOutput("t1_alpha0_hold", bus.alpha0, 16384);
      applyStimulus(2'b00, 2'b00);

      // Channel 1 at negative full scale
      bus.a1 = -18'sd32768; bus.b1 = -18'sd32768;
      applyStimulus(2'b10, 2'b00);
      #1 checkOutput("t2_grant", bus.in_ready, 2);
      tick();
      applyStimulus(2'b00, 2'b00);
      tick(2);
      checkOutput("t2_ov", bus.out_valid, 2);
      checkOutput("t2_alpha1", bus.alpha1, -32768);
      checkOutput("t2_beta1", bus.beta1, -56754);
      applyStimulus(2'b00, 2'b11);
      tick();

      // Both channels requesting continuously: alternate grants every 3 cycles
      bus.a0 = 18'sd100; bus.b0 = 18'sd1; bus.a1 = 18'sd200; bus.b1 = 18'sd2;
      applyStimulus(2'b11, 2'b11);
      for (int k = 0; k < 4; k++) begin
         #1 checkOutput($sformatf("t3_grant%0d", k), bus.in_ready, (k % 2 == 0) ? 1 : 2);
         tick();
         checkOutput($sformatf("t3_start%0d", k), bus.cl_start, 1);
         tick(2);
      end
      applyStimulus(2'b00, 2'b11);
      #1 checkOutput("t3_alpha0", bus.alpha0, 100);
      checkOutput("t3_beta0", bus.beta0, 58);
      checkOutput("t3_alpha1", bus.alpha1, 200);
      checkOutput("t3_beta1", bus.beta1, 117);
      tick();

      // Channel 0 result not consumed: channel 1 gets every grant until released
      applyStimulus(2'b11, 2'b10);
      #1 checkOutput("t4_grant_b0", bus.in_ready, 1);
      tick(3);
      checkOutput("t4_ov_b1", bus.out_valid, 1);
      checkOutput("t4_grant_b1", bus.in_ready, 2);
      tick(3);
      checkOutput("t4_none", bus.in_ready, 0);
      checkOutput("t4_ov_both", bus.out_valid, 3);
      tick();
      checkOutput("t4_grant_b2", bus.in_ready, 2);
      applyStimulus(2'b11, 2'b11);
      tick();
      applyStimulus(2'b11, 2'b10);
      #1 checkOutput("t4_released", bus.out_valid, 0);
      tick(2);
      checkOutput("t4_grant_ch0", bus.in_ready, 1);
      applyStimulus(2'b00, 2'b11);
      tick(4);

      // Reset one cycle after cl_start discards the operation and clears rr_ptr
      bus.a0 = 18'sd777;
      applyStimulus(2'b01, 2'b11);
      #1 checkOutput("t5_grant", bus.in_ready, 1);
      tick();
      applyStimulus(2'b00, 2'b11);
      #1 checkOutput("t5_start", bus.cl_start, 1);
      tick();
      rstb = 1'b0;
      #1 checkOutput("t5_busy", bus.busy, 0);
      checkOutput("t5_ov", bus.out_valid, 0);
      checkOutput("t5_cl_start", bus.cl_start, 0);
      checkOutput("t5_alpha0", bus.alpha0, 0);
      checkOutput("t5_cl_a", bus.cl_a, 0);
      tick();
      rstb = 1'b1;
      tick();
      checkOutput("t5_no_result", bus.out_valid, 0);
      applyStimulus(2'b11, 2'b11);
      #1 checkOutput("t5_rr_reset", bus.in_ready, 1);
      tick();
      applyStimulus(2'b00, 2'b11);
      tick(3);

      // cl_done low during capture sets a sticky error, result still delivered
      bus.a1 = 18'sd5; bus.b1 = 18'sd0;
      applyStimulus(2'b10, 2'b11);
      #1 checkOutput("t6_grant", bus.in_ready, 2);
      tick();
      applyStimulus(2'b00, 2'b11);
      tick();
      forceDoneLow = 1'b1;
      #1 checkOutput("t6_err_before", bus.err, 0);
      tick();
      forceDoneLow = 1'b0;
      checkOutput("t6_err_set", bus.err, 1);
      checkOutput("t6_ov", bus.out_valid, 2);
      checkOutput("t6_alpha1", bus.alpha1, 5);
      checkOutput("t6_beta1", bus.beta1, 2);
      tick(2);
      checkOutput("t6_err_sticky", bus.err, 1);
      rstb = 1'b0;
      #1 checkOutput("t6_err_reset", bus.err, 0);
      tick();
      rstb = 1'b1;
      tick();

      // LAT=3 instance: one cl_start every 5 cycles, alternating channels
      bus3.a0 = 18'sd1000;  bus3.b0 = 18'sd0;
      bus3.a1 = -18'sd1000; bus3.b1 = 18'sd500;
      bus3.in_valid = 2'b11; bus3.out_ready = 2'b11;
      for (int c = 0; c < 10; c++) begin
         #1;
         checkOutput($sformatf("t7_start_c%0d", c), bus3.cl_start, (c % 5 == 1) ? 1 : 0);
         checkOutput($sformatf("t7_ready_c%0d", c), bus3.in_ready,
                     (c == 0) ? 1 : ((c == 5) ? 2 : 0));
         checkOutput($sformatf("t7_ov_c%0d", c), bus3.out_valid, (c == 5) ? 1 : 0);
         tick();
      end
      bus3.in_valid = 2'b00;
      #1 checkOutput("t7_ov_ch1", bus3.out_valid, 2);
      checkOutput("t7_alpha0", bus3.alpha0, 1000);
      checkOutput("t7_beta0", bus3.beta0, 577);
      checkOutput("t7_alpha1", bus3.alpha1, -1000);
      checkOutput("t7_beta1", bus3.beta1, 0);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
